// File: rtl/led_scan_decoder.sv
// Decodes a multiplexed, active-low 8-digit seven-segment scan back into per-digit hex values.
// Optional macro LED_SCAN_DECODER_POINT_EN captures and publishes the decimal points.
module led_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] an,
  input  logic [7:0] seg,
  output logic [3:0] led1Number,
  output logic [3:0] led2Number,
  output logic [3:0] led3Number,
  output logic [3:0] led4Number,
  output logic [3:0] led5Number,
  output logic [3:0] led6Number,
  output logic [3:0] led7Number,
  output logic [3:0] led8Number,
  output logic [7:0] point,
  output logic       frame_valid,
  output logic       frame_error,
  output logic       locked
);

`ifdef LED_SCAN_DECODER_POINT_EN
  localparam int unsigned SEG_W = 8;
`else
  localparam int unsigned SEG_W = 7;
  logic unused_dp;
  assign unused_dp = seg[7];
`endif

  localparam logic [7:0]  SETTLE_LIM = 8'(SETTLE_CYCLES);
  localparam logic [23:0] IDLE_LIM   = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {SYNC, CAPTURE, LOST} state_t;

  state_t           state, state_nx;
  logic [7:0]       an_r, an_p;
  logic [SEG_W-1:0] seg_r, seg_p;
  logic [7:0]       settle_cnt, settle_nx;
  logic [23:0]      idle_cnt, idle_nx;
  logic [7:0]       mask, mask_nx;
  logic [3:0]       shadow [8];
  logic [3:0]       shadow_nx [8];
  logic [3:0]       led [8];
  logic [3:0]       lows;
  logic [4:0]       dec;
  logic [2:0]       idx;
  logic             same, reach, sample, multi, bad, err, pub;

  // Returns {valid, value} for an active-high a..g pattern.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    case (pat)
      7'h3F: decode = 5'h10;
      7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;
      7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;
      7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;
      7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;
      7'h6F: decode = 5'h19;
      7'h77: decode = 5'h1A;
      7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;
      7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;
      7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  // Dwell tracking: exactly one sample fires on the cycle the count first reaches the limit.
  always_comb begin
    same = (an_r == an_p) && (seg_r == seg_p);
    if (an_r == '1)                    settle_nx = '0;
    else if (!same)                    settle_nx = 8'd1;
    else if (settle_cnt == SETTLE_LIM) settle_nx = settle_cnt;
    else                               settle_nx = settle_cnt + 8'd1;
    reach  = (settle_nx == SETTLE_LIM) && (settle_cnt != SETTLE_LIM);
    lows   = 4'($countones(~an_r));
    sample = reach && (lows == 4'd1);
    multi  = reach && (lows > 4'd1);
    if (multi) settle_nx = '0;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!an_r[i]) idx = i[2:0];
    end
    dec = decode(~seg_r[6:0]);
    bad = sample && !dec[4];
  end

`ifdef LED_SCAN_DECODER_POINT_EN
  logic [7:0] shadow_pt, shadow_pt_nx, point_r;
  assign point = point_r;
`else
  assign point = '0;
`endif

  always_comb begin
    state_nx  = state;
    mask_nx   = mask;
    shadow_nx = shadow;
    idle_nx   = '0;
    pub       = 1'b0;
    err       = multi || bad;
`ifdef LED_SCAN_DECODER_POINT_EN
    shadow_pt_nx = shadow_pt;
`endif
    if (state == CAPTURE) begin
      idle_nx = sample ? '0 : idle_cnt + 24'd1;
      if (mask == '1) begin
        // Full mask is published one edge later; a coincident error drops it.
        mask_nx = '0;
        pub     = !err;
      end else if (bad) begin
        mask_nx  = '0;
        state_nx = SYNC;
      end else if (sample && mask[idx]) begin
        err      = 1'b1;
        mask_nx  = '0;
        state_nx = SYNC;
        if (idx == 3'd0) begin
          mask_nx      = 8'h01;
          shadow_nx[0] = dec[3:0];
`ifdef LED_SCAN_DECODER_POINT_EN
          shadow_pt_nx[0] = ~seg_r[7];
`endif
          state_nx     = CAPTURE;
        end
      end else if (sample) begin
        mask_nx[idx]   = 1'b1;
        shadow_nx[idx] = dec[3:0];
`ifdef LED_SCAN_DECODER_POINT_EN
        shadow_pt_nx[idx] = ~seg_r[7];
`endif
      end else if (idle_cnt == IDLE_LIM) begin
        mask_nx  = '0;
        state_nx = LOST;
      end
    end else if (sample && !bad && idx == 3'd0) begin
      mask_nx      = 8'h01;
      shadow_nx[0] = dec[3:0];
`ifdef LED_SCAN_DECODER_POINT_EN
      shadow_pt_nx[0] = ~seg_r[7];
`endif
      state_nx     = CAPTURE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= SYNC;
      an_r        <= '1;
      an_p        <= '1;
      seg_r       <= '1;
      seg_p       <= '1;
      settle_cnt  <= '0;
      idle_cnt    <= '0;
      mask        <= '0;
      shadow      <= '{default: '0};
      led         <= '{default: '0};
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
`ifdef LED_SCAN_DECODER_POINT_EN
      shadow_pt   <= '0;
      point_r     <= '0;
`endif
    end else begin
      state       <= state_nx;
      an_r        <= an;
      an_p        <= an_r;
      seg_r       <= seg[SEG_W-1:0];
      seg_p       <= seg_r;
      settle_cnt  <= settle_nx;
      idle_cnt    <= idle_nx;
      mask        <= mask_nx;
      shadow      <= shadow_nx;
      frame_valid <= pub;
      frame_error <= err;
      if (pub) led <= shadow;
`ifdef LED_SCAN_DECODER_POINT_EN
      shadow_pt   <= shadow_pt_nx;
      if (pub) point_r <= shadow_pt;
`endif
    end
  end

  assign locked     = (state == CAPTURE);
  assign led1Number = led[0];
  assign led2Number = led[1];
  assign led3Number = led[2];
  assign led4Number = led[3];
  assign led5Number = led[4];
  assign led6Number = led[5];
  assign led7Number = led[6];
  assign led8Number = led[7];

endmodule

// File: tb/tb_led_scan_decoder.sv
// Directed bench for led_scan_decoder: hex decode table, free scan order, glitches,
// duplicate digits, mid-frame reset, lock timeout and protocol errors.
module tb_led_scan_decoder;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned TO     = 64;
  localparam int unsigned DWELL  = 10;

`ifdef LED_SCAN_DECODER_POINT_EN
  localparam logic [7:0] PT0 = 8'h10;
  localparam logic [7:0] PT1 = 8'h02;
`else
  localparam logic [7:0] PT0 = 8'h00;
  localparam logic [7:0] PT1 = 8'h00;
`endif

  typedef struct {
    logic [6:0] pat;
    logic       dp;
    logic [3:0] exp;
  } vec_t;

  vec_t tv [16];

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] an = '1;
  logic [7:0] seg = '1;
  logic [3:0] l1, l2, l3, l4, l5, l6, l7, l8;
  logic [7:0] point;
  logic       frame_valid, frame_error, locked;
  logic [3:0] led [8];

  int n_checks = 0;
  int n_fail   = 0;
  int fv_cnt   = 0;
  int fe_cnt   = 0;

  assign led[0] = l1;
  assign led[1] = l2;
  assign led[2] = l3;
  assign led[3] = l4;
  assign led[4] = l5;
  assign led[5] = l6;
  assign led[6] = l7;
  assign led[7] = l8;

  always #5 clk = ~clk;

  led_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .an(an), .seg(seg),
    .led1Number(l1), .led2Number(l2), .led3Number(l3), .led4Number(l4),
    .led5Number(l5), .led6Number(l6), .led7Number(l7), .led8Number(l8),
    .point(point), .frame_valid(frame_valid), .frame_error(frame_error), .locked(locked)
  );

  always @(posedge clk) begin
    if (frame_valid) fv_cnt++;
    if (frame_error) fe_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned fval(input int unsigned k, input int unsigned d);
    return (8 * k + d + 1) % 16;
  endfunction

  task automatic put(input logic [7:0] a, input logic [7:0] s, input int unsigned cyc);
    an  = a;
    seg = s;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic digit(input int unsigned d, input int unsigned v, input int unsigned cyc);
    logic [7:0] one;
    one = 8'h01;
    put(~(one << d), {~tv[v].dp, ~tv[v].pat}, cyc);
  endtask

  task automatic check_frame(input int unsigned k, input logic [7:0] pt, input string tag);
    for (int unsigned d = 0; d < 8; d++)
      check($sformatf("%s_led%0d", tag, d + 1), 32'(led[d]), 32'(tv[fval(k, d)].exp));
    check({tag, "_point"}, 32'(point), 32'(pt));
  endtask

  task automatic check_status(input string tag, input int fv, input int fe, input logic lk);
    check({tag, "_fv_count"}, 32'(fv_cnt), 32'(fv));
    check({tag, "_fe_count"}, 32'(fe_cnt), 32'(fe));
    check({tag, "_locked"}, 32'(locked), 32'(lk));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    tv[0]  = '{7'h3F, 1'b0, 4'h0};
    tv[1]  = '{7'h06, 1'b0, 4'h1};
    tv[2]  = '{7'h5B, 1'b0, 4'h2};
    tv[3]  = '{7'h4F, 1'b0, 4'h3};
    tv[4]  = '{7'h66, 1'b0, 4'h4};
    tv[5]  = '{7'h6D, 1'b1, 4'h5};
    tv[6]  = '{7'h7D, 1'b0, 4'h6};
    tv[7]  = '{7'h07, 1'b0, 4'h7};
    tv[8]  = '{7'h7F, 1'b0, 4'h8};
    tv[9]  = '{7'h6F, 1'b0, 4'h9};
    tv[10] = '{7'h77, 1'b1, 4'hA};
    tv[11] = '{7'h7C, 1'b0, 4'hB};
    tv[12] = '{7'h39, 1'b0, 4'hC};
    tv[13] = '{7'h5E, 1'b0, 4'hD};
    tv[14] = '{7'h79, 1'b0, 4'hE};
    tv[15] = '{7'h71, 1'b0, 4'hF};

    repeat (3) @(negedge clk);
    for (int unsigned d = 0; d < 8; d++) check($sformatf("rst_led%0d", d + 1), 32'(led[d]), 32'h0);
    check("rst_point", 32'(point), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_fe", 32'(frame_error), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    reset_n = 1'b1;
    put('1, '1, 3);

    // In-order scan from SYNC, values 1..8
    for (int unsigned d = 0; d < 8; d++) digit(d, fval(0, d), DWELL);
    put('1, '1, 3);
    check_status("f0", 1, 0, 1'b1);
    check_frame(0, PT0, "f0");

    // Reverse order while locked, values 9..F,0
    for (int d = 7; d >= 0; d--) digit(int'(d), fval(1, int'(d)), DWELL);
    put('1, '1, 3);
    check_status("f1", 2, 0, 1'b1);
    check_frame(1, PT1, "f1");

    // Two-cycle glitches between dwells are ignored; outputs hold mid-frame
    for (int unsigned d = 0; d < 8; d++) begin
      put(8'hFE, 8'h00, 2);
      digit(d, fval(0, d), DWELL);
      if (d == 3) begin
        check("glitch_mid_led8", 32'(led[7]), 32'(tv[fval(1, 7)].exp));
        check("glitch_mid_fv", 32'(fv_cnt), 32'd2);
      end
    end
    put('1, '1, 3);
    check_status("glitch", 3, 0, 1'b1);
    check_frame(0, PT0, "glitch");

    // Duplicate digit 2 in scan 1,2,3,2
    digit(0, fval(0, 0), DWELL);
    digit(1, fval(0, 1), DWELL);
    digit(2, fval(0, 2), DWELL);
    digit(1, fval(0, 1), DWELL);
    put('1, '1, 3);
    check_status("dup", 3, 1, 1'b0);

    // Reset after five digits discards the partial frame
    for (int unsigned d = 0; d < 5; d++) digit(d, fval(1, d), DWELL);
    check("pre_rst_locked", 32'(locked), 32'h1);
    an = '1;
    seg = '1;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int unsigned d = 0; d < 8; d++) check($sformatf("mid_rst_led%0d", d + 1), 32'(led[d]), 32'h0);
    check("mid_rst_point", 32'(point), 32'h0);
    check("mid_rst_locked", 32'(locked), 32'h0);
    check("mid_rst_fv", 32'(frame_valid), 32'h0);
    check("mid_rst_fe", 32'(frame_error), 32'h0);
    reset_n = 1'b1;
    for (int unsigned d = 5; d < 8; d++) digit(d, fval(1, d), DWELL);
    for (int unsigned d = 0; d < 7; d++) digit(d, fval(0, d), DWELL);
    check("post_rst_7_fv", 32'(fv_cnt), 32'd3);
    digit(7, fval(0, 7), DWELL);
    put('1, '1, 3);
    check_status("post_rst", 4, 1, 1'b1);
    check_frame(0, PT0, "post_rst");

    // Blanking only: lock lost after the timeout, outputs retained
    n = 0;
    while (locked && n < 4 * TO) begin
      @(negedge clk);
      n++;
    end
    check("timeout_window", 32'((n >= TO - 16) && (n <= TO)), 32'h1);
    check_status("timeout", 4, 1, 1'b0);
    check_frame(0, PT0, "timeout");

    // Two digit selects low at once
    put(8'hFC, {1'b1, ~tv[0].pat}, 6);
    put('1, '1, 3);
    check_status("multi", 4, 2, 1'b0);

    // Unrecognised segment pattern on digit 1
    put(8'hFE, 8'hFF, 6);
    put('1, '1, 3);
    check_status("badpat", 4, 3, 1'b0);

    // Recovery scan
    for (int unsigned d = 0; d < 8; d++) digit(d, fval(1, d), DWELL);
    put('1, '1, 3);
    check_status("recover", 5, 3, 1'b1);
    check_frame(1, PT1, "recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
